// File: rtl/aclk_pkg.sv
// Shared constants for the clkb edge counter: edge-select encodings and
// default sizing.
package aclk_pkg;

  localparam int CNT_W_DEF       = 8;
  localparam int SYNC_STAGES_DEF = 2;

  localparam logic [1:0] SEL_NONE = 2'b00;
  localparam logic [1:0] SEL_RISE = 2'b01;
  localparam logic [1:0] SEL_FALL = 2'b10;
  localparam logic [1:0] SEL_BOTH = 2'b11;

  // An edge is selected when its kind is enabled in the select field.
  function automatic logic edge_sel(input logic rise, input logic fall,
                                    input logic [1:0] r0);
    logic want_rise;
    logic want_fall;
    want_rise = (r0 & SEL_RISE) != SEL_NONE;
    want_fall = (r0 & SEL_FALL) != SEL_NONE;
    return (rise && want_rise) || (fall && want_fall);
  endfunction

endpackage

// File: rtl/aclk_sync.sv
// Flop-chain synchronizer for a single asynchronous bit; every stage
// clears on synchronous reset.
module aclk_sync
  import aclk_pkg::*;
#(
  parameter int SYNC_STAGES = SYNC_STAGES_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [SYNC_STAGES-1:0] stage;

  always_ff @(posedge clk) begin
    if (rst) begin
      stage <= '0;
    end else begin
      stage <= {stage[SYNC_STAGES-2:0], d};
    end
  end

  assign q = stage[SYNC_STAGES-1];

endmodule

// File: rtl/aclk_edge_counter.sv
// Counts selected edges of an asynchronous signal clkb in the clka domain,
// with a registered per-edge pulse and a sticky wrap flag.
module aclk_edge_counter
  import aclk_pkg::*;
#(
  parameter int CNT_W       = CNT_W_DEF,
  parameter int SYNC_STAGES = SYNC_STAGES_DEF
) (
  input  logic             clka,
  input  logic             rst,
  input  logic             clkb,
  input  logic             cnt,
  input  logic [1:0]       r0,
  output logic [CNT_W-1:0] count,
  output logic             edge_pulse,
  output logic             ovf,
  output logic             sync_b
);

  logic prev;
  logic rise;
  logic fall;
  logic sel;

  aclk_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .clk (clka),
    .rst (rst),
    .d   (clkb),
    .q   (sync_b)
  );

  always_comb begin
    rise = sync_b & ~prev;
    fall = ~sync_b & prev;
    sel  = edge_sel(rise, fall, r0);
  end

  // The pulse reports every selected edge; only the counter is gated by cnt.
  always_ff @(posedge clka) begin
    if (rst) begin
      prev       <= 1'b0;
      count      <= '0;
      edge_pulse <= 1'b0;
      ovf        <= 1'b0;
    end else begin
      prev       <= sync_b;
      edge_pulse <= sel;
      if (sel && cnt) begin
        count <= count + CNT_W'(1);
        if (&count) begin
          ovf <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_aclk_edge_counter.sv
// Bench for aclk_edge_counter: an 8-bit and a 4-bit instance share stimulus
// and are checked every cycle against a history-based model of clkb edges.
module tb_aclk_edge_counter;

  localparam int SS   = 2;
  localparam int MAXC = 16384;

  logic       clka = 1'b0;
  logic       rst;
  logic       clkb;
  logic       cnt;
  logic [1:0] r0;

  logic [7:0] count8;
  logic       pulse8, ovf8, sync8;
  logic [3:0] count4;
  logic       pulse4, ovf4, sync4;

  int total = 0;
  int bad   = 0;

  always #5 clka = ~clka;

  aclk_edge_counter #(.CNT_W(8), .SYNC_STAGES(SS)) dut8 (
    .clka(clka), .rst(rst), .clkb(clkb), .cnt(cnt), .r0(r0),
    .count(count8), .edge_pulse(pulse8), .ovf(ovf8), .sync_b(sync8)
  );

  aclk_edge_counter #(.CNT_W(4), .SYNC_STAGES(SS)) dut4 (
    .clka(clka), .rst(rst), .clkb(clkb), .cnt(cnt), .r0(r0),
    .count(count4), .edge_pulse(pulse4), .ovf(ovf4), .sync_b(sync4)
  );

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", nm, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  // rh[n]: reset seen at clka edge n; hh[n]: clkb value captured at edge n.
  logic rh [0:MAXC-1];
  logic hh [0:MAXC-1];
  int   cyc        = 0;
  int   incs       = 0;   // increments since last reset
  logic m_pulse    = 1'b0;
  int   pulse_seen = 0;   // DUT pulses observed on the 8-bit instance

  // A captured clkb value reaches sync_b SS-1 edges later, unless a reset
  // edge falls inside that window.
  function automatic logic sync_after(input int m);
    if (m - SS + 1 < 0) return 1'b0;
    for (int j = 0; j < SS; j++) if (rh[m-j]) return 1'b0;
    return hh[m-SS+1];
  endfunction

  function automatic logic prev_after(input int m);
    if (m < 0) return 1'b0;
    if (rh[m]) return 1'b0;
    return sync_after(m - 1);
  endfunction

  always @(posedge clka) begin
    int   n;
    logic s1, p1, rs, fl, sl;
    n = cyc;
    if (n >= MAXC) begin
      $display("FAIL cycle_budget: got %0d want <%0d", n, MAXC);
      $fatal(1);
    end
    rh[n] = rst;
    hh[n] = rst ? 1'b0 : clkb;
    if (rst) begin
      incs    = 0;
      m_pulse = 1'b0;
    end else begin
      s1 = sync_after(n - 1);
      p1 = prev_after(n - 1);
      rs = s1 && !p1;
      fl = !s1 && p1;
      sl = (rs && r0[0]) || (fl && r0[1]);
      m_pulse = sl;
      if (sl && cnt) incs++;
    end
    cyc++;
    #1;
    check("count8", count8, incs % 256);
    check("ovf8",   ovf8,   incs >= 256);
    check("pulse8", pulse8, m_pulse);
    check("sync8",  sync8,  sync_after(n));
    check("count4", count4, incs % 16);
    check("ovf4",   ovf4,   incs >= 16);
    check("pulse4", pulse4, m_pulse);
    check("sync4",  sync4,  sync_after(n));
    if (pulse8 === 1'b1) pulse_seen++;
  end

  // ---------------- stimulus ----------------
  task automatic tick(input int k);
    repeat (k) @(negedge clka);
  endtask

  task automatic do_reset(input logic lvl);
    rst  = 1'b1;
    clkb = lvl;
    tick(2);
    rst  = 1'b0;
  endtask

  initial begin
    int base;
    logic [1:0] sweep_sel [4];
    int         sweep_exp [4];
    sweep_sel = '{2'b00, 2'b01, 2'b10, 2'b11};
    sweep_exp = '{0, 5, 5, 10};

    rst = 1'b1; clkb = 1'b1; cnt = 1'b0; r0 = 2'b00;

    // Reset with clkb high, then the held-high level counts as one rise.
    tick(2);
    check("rst_count", count8, 0);
    check("rst_ovf",   ovf8,   0);
    check("rst_pulse", pulse8, 0);
    check("rst_sync",  sync8,  0);
    rst = 1'b0; r0 = 2'b01; cnt = 1'b1;
    tick(3);
    check("rel_count", count8, 1);

    // Rising only: 0,0,1 levels.
    do_reset(1'b0);
    r0 = 2'b01; cnt = 1'b1;
    base = pulse_seen;
    clkb = 1'b0; tick(8);
    clkb = 1'b1; tick(4);
    clkb = 1'b0; tick(4);
    check("rise_count",  count8, 1);
    check("rise_pulses", pulse_seen - base, 1);

    // Edge-select sweep over five full clkb periods.
    for (int s = 0; s < 4; s++) begin
      do_reset(1'b0);
      r0 = sweep_sel[s]; cnt = 1'b1;
      for (int p = 0; p < 5; p++) begin
        clkb = 1'b0; tick(4);
        clkb = 1'b1; tick(4);
      end
      clkb = 1'b0; tick(4);
      check("sweep_count", count8, sweep_exp[s]);
    end

    // Enable gating: three counted edges then three uncounted.
    do_reset(1'b0);
    r0 = 2'b11; cnt = 1'b1;
    base = pulse_seen;
    tick(2);
    for (int e = 0; e < 6; e++) begin
      if (e == 3) cnt = 1'b0;
      clkb = ~clkb; tick(4);
    end
    check("gate_count",  count8, 3);
    check("gate_pulses", pulse_seen - base, 6);

    // Wrap on the 4-bit instance: 17 rises.
    do_reset(1'b0);
    r0 = 2'b01; cnt = 1'b1;
    for (int p = 0; p < 17; p++) begin
      clkb = 1'b1; tick(4);
      clkb = 1'b0; tick(4);
    end
    check("wrap_count4", count4, 1);
    check("wrap_ovf4",   ovf4,   1);
    check("wrap_count8", count8, 17);
    check("wrap_ovf8",   ovf8,   0);
    tick(10);
    check("wrap_ovf4_sticky", ovf4, 1);
    rst = 1'b1; tick(1); rst = 1'b0;
    check("wrap_ovf4_clr", ovf4, 0);

    // Latency: clkb rises just before edge k.
    do_reset(1'b0);
    r0 = 2'b01; cnt = 1'b1;
    tick(3);
    clkb = 1'b1;
    tick(1);
    check("lat_sync_k",    sync8,  0);
    tick(1);
    check("lat_sync_k1",   sync8,  1);
    check("lat_count_k1",  count8, 0);
    tick(1);
    check("lat_count_k2",  count8, 1);

    // Randomized traffic with occasional resets and mid-stream select changes.
    for (int i = 0; i < 400; i++) begin
      clkb = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 7) == 0) r0 = 2'($urandom_range(0, 3));
      cnt = ($urandom_range(0, 3) != 0);
      rst = ($urandom_range(0, 49) == 0);
      tick($urandom_range(1, 6));
    end
    rst = 1'b0;
    tick(6);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/aclk_edge_counter.md
Name: aclk_edge_counter

Overview:
- Counts edges of a foreign, asynchronous signal `clkb` inside the `clka` clock domain.
- `clkb` is synchronized through a flop chain, edge-detected, filtered by an edge-select field, and counted when enabled.
- Used as a clock-activity / event monitor between unrelated clock domains.

Parameters:
- CNT_W, 8, width of the edge counter.
- SYNC_STAGES, 2, number of synchronizer flops for `clkb` (legal 2..4).

Ports:
- clka  input  1  sole clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- clkb  input  1  asynchronous foreign signal whose edges are counted.
- cnt  input  1  count enable, sampled on `clka`.
- r0  input  2  edge select: r0[0]=1 counts rising edges, r0[1]=1 counts falling edges, both=1 counts both, 00 counts none.
- count  output  CNT_W  current edge count.
- edge_pulse  output  1  one-cycle pulse per selected edge (independent of `cnt`).
- ovf  output  1  sticky wrap flag.
- sync_b  output  1  synchronized level of `clkb` (last synchronizer stage).

Behaviour:
- Reset: while `rst`=1 at a `clka` edge, the following all load 0:
  - all synchronizer stages
  - the previous-level register `prev`
  - `count`, `edge_pulse`, `ovf`
- Reset has priority over every other event.
- Synchronizer: stage[0] <= `clkb`; stage[i] <= stage[i-1]. `sync_b` = stage[SYNC_STAGES-1]. `prev` <= `sync_b` each cycle.
- Edge detect (combinational):
  - rise = `sync_b` & ~`prev`
  - fall = ~`sync_b` & `prev`
  - sel = (rise & r0[0]) | (fall & r0[1])
- `edge_pulse` <= sel (registered; high exactly one cycle per selected edge).
- Count update: if sel & `cnt`, then `count` <= `count` + 1 (modulo 2^CNT_W). Otherwise `count` holds.
- Wrap: when `count` = 2^CNT_W-1 and an increment occurs, `count` becomes 0 and `ovf` <= 1. `ovf` is cleared only by `rst`.
- Latency: a `clkb` transition first captured by stage[0] at `clka` edge k is:
  - visible on `sync_b` after edge k+SYNC_STAGES-1;
  - reflected in `count` / `edge_pulse` after edge k+SYNC_STAGES.
- `r0` and `cnt` are sampled on the same edge that updates `count`. Changing them mid-stream affects only edges detected from that cycle on.
- `clkb` pulses narrower than one `clka` period may be missed. This is by design; no pulse stretching.
- `clkb` held high through reset release: one rising edge is detected after SYNC_STAGES cycles. This edge is counted if enabled.
- No combinational path from any input to any output.

Decomposition:
- Shared package `aclk_pkg`:
  - edge-select encoding constants: SEL_NONE=2'b00, SEL_RISE=2'b01, SEL_FALL=2'b10, SEL_BOTH=2'b11
  - default CNT_W and SYNC_STAGES
- One natural sub-module: `aclk_sync` (parameterized SYNC_STAGES flop chain with synchronous reset).
- Edge detect, counter and overflow logic stay in the top.

Test Plan:
- Reset: `rst`=1 for 2 cycles with `clkb`=1 -> count=0, ovf=0, edge_pulse=0, sync_b=0. After release with r0=01, cnt=1 -> count=1 after SYNC_STAGES+1 cycles.
- Rising only: r0=01, cnt=1, `clkb` toggled 0,0,1 (each level held 4 `clka` cycles) -> exactly 1 edge_pulse, count=1, no count on the falling side.
- Edge select sweep: 5 full `clkb` periods (each level held 4 cycles). Required count per setting:
  - r0=00 -> 0
  - r0=01 -> 5
  - r0=10 -> 5
  - r0=11 -> 10
- Enable gating: r0=11, cnt=1 for the first 3 edges, then cnt=0 for the next 3 -> count=3; edge_pulse fires 6 times.
- Wrap: CNT_W=4, r0=01, cnt=1, 17 rising edges -> count=1, ovf=1. ovf stays 1 until `rst`, then returns to 0.
- Latency check: `clkb` rises just before `clka` edge k -> sync_b=1 after edge k+1, count increments after edge k+2 (SYNC_STAGES=2).
